// File: rtl/tron_plot_arbiter.sv
// Shares the VGA pixel-write port between four players (round-robin, 1 pixel / 2 cycles) and a full-screen clear.
// Grant-to-plot latency 1 cycle; clear preempts grants, and player requests wait un-acked until the sweep ends.
module tron_plot_arbiter #(
  parameter logic [7:0] X_MAX        = 8'd159,
  parameter logic [6:0] Y_MAX        = 7'd119,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000,
  parameter logic [2:0] P1_COLOUR    = 3'b001,
  parameter logic [2:0] P2_COLOUR    = 3'b010,
  parameter logic [2:0] P3_COLOUR    = 3'b100,
  parameter logic [2:0] P4_COLOUR    = 3'b110
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [14:0] p1,
  input  logic [14:0] p2,
  input  logic [14:0] p3,
  input  logic [14:0] p4,
  input  logic        clear_req,
  output logic [3:0]  ack,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        clear_busy,
  output logic        clear_done
);

  typedef enum logic [1:0] {S_IDLE, S_PLOT, S_CLEAR} state_t;

  state_t     r_state;
  logic [1:0] r_rr_ptr;
  logic [3:0] r_ack;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_colour;
  logic       r_plot;
  logic       r_clear_busy;
  logic       r_clear_done;

  logic        w_found;
  logic [1:0]  w_win;
  logic [1:0]  w_idx;
  logic [14:0] w_pos;
  logic [2:0]  w_col;
  logic        w_in_range;

  // First requester at or after the pointer wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_rr_ptr;
    w_idx   = r_rr_ptr;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_rr_ptr + 2'(i);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_pos = p1;
    w_col = P1_COLOUR;
    case (w_win)
      2'd0: begin w_pos = p1; w_col = P1_COLOUR; end
      2'd1: begin w_pos = p2; w_col = P2_COLOUR; end
      2'd2: begin w_pos = p3; w_col = P3_COLOUR; end
      default: begin w_pos = p4; w_col = P4_COLOUR; end
    endcase
    w_in_range = (w_pos[14:7] <= X_MAX) && (w_pos[6:0] <= Y_MAX);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= 2'd0;
      r_ack        <= 4'd0;
      r_x          <= 8'd0;
      r_y          <= 7'd0;
      r_colour     <= 3'd0;
      r_plot       <= 1'b0;
      r_clear_busy <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_clear_done <= 1'b0;
          if (clear_req) begin
            r_state      <= S_CLEAR;
            r_x          <= 8'd0;
            r_y          <= 7'd0;
            r_colour     <= CLEAR_COLOUR;
            r_plot       <= 1'b1;
            r_clear_busy <= 1'b1;
            r_ack        <= 4'd0;
          end else if (w_found) begin
            r_state  <= S_PLOT;
            r_x      <= w_pos[14:7];
            r_y      <= w_pos[6:0];
            r_colour <= w_col;
            r_plot   <= w_in_range;
            r_ack    <= 4'b0001 << w_win;
            r_rr_ptr <= w_win + 2'd1;
          end else begin
            r_plot <= 1'b0;
            r_ack  <= 4'd0;
          end
        end
        S_PLOT: begin
          r_state <= S_IDLE;
          r_plot  <= 1'b0;
          r_ack   <= 4'd0;
        end
        S_CLEAR: begin
          if (r_x == X_MAX && r_y == Y_MAX) begin
            r_state      <= S_IDLE;
            r_plot       <= 1'b0;
            r_clear_busy <= 1'b0;
            r_clear_done <= 1'b1;
          end else if (r_x == X_MAX) begin
            r_x <= 8'd0;
            r_y <= r_y + 7'd1;
          end else begin
            r_x <= r_x + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack        = r_ack;
  assign x          = r_x;
  assign y          = r_y;
  assign colour     = r_colour;
  assign plot       = r_plot;
  assign clear_busy = r_clear_busy;
  assign clear_done = r_clear_done;

endmodule
